uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the core.
- Consumes the core's word address, write data, byte-write enables and read enable; returns registered read data.
- The top level ORs this block's read data with the RAM's read data, so the block drives 0 when not selected.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on a single TX line.

Parameters:
- BASE_ADDR, 30'h0400_0000, word address of the DATA register; STATUS is at BASE_ADDR+1.
- CLK_DIV, 104, clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  30  word address from the core
- wdata  in  32  store data from the core
- we  in  4  byte-lane write enables
- re  in  1  read enable
- rdata  out  32  read data, valid the cycle after re; 0 when not selected
- tx  out  1  serial output; idles high

Behaviour:
- Reset values: tx=1, rdata=0, FIFO empty, overflow=0, FSM in IDLE, baud counter 0. Reset mid-frame aborts the frame; tx is 1 after the reset edge.
- Decode: sel_data = (addr==BASE_ADDR); sel_stat = (addr==BASE_ADDR+1).
- DATA write: sel_data & we[0] pushes wdata[7:0]. we[0]=0 means no push, whatever we[3:1] is.
- Push rule: the push is accepted if count<FIFO_DEPTH, or if the FSM pops in the same cycle. Otherwise the byte is dropped and the sticky overflow bit is set.
- Reads:
  - rdata is registered. On re&sel_stat, rdata is the STATUS word on the next cycle.
  - On re&sel_data, rdata is 0 on the next cycle.
  - In every other cycle rdata is 0.
- STATUS word:
  - bit0 busy = FSM not IDLE or FIFO non-empty
  - bit1 full
  - bit2 overflow
  - bits[12:8] count (zero-extended)
  - all other bits 0
- Overflow clear: a STATUS read clears overflow on the same edge. If overflow is set in that same cycle, the set wins. The value returned is the pre-clear value.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the shift register, bit index=0, baud counter=CLK_DIV-1, tx<=0, go to START.
  - Each non-IDLE state holds for CLK_DIV cycles; the baud counter decrements and its state action fires at 0.
  - START→DATA: tx<=shift[0].
  - DATA: after bit 7 go to STOP with tx<=1; otherwise shift right and drive the next bit.
  - STOP→IDLE after CLK_DIV cycles. A following byte starts a new START in the IDLE cycle, so the gap between frames is 1 clock.
- Latency: a write captured at edge E0 drives tx low at edge E1. A frame is 10*CLK_DIV cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. count uses a log2(FIFO_DEPTH)+1-bit counter.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP.
  - It drives the even parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame is 11*CLK_DIV cycles.
  - STATUS bit3 reads 1.
- When undefined: no PARITY state, 8N1 framing, STATUS bit3 reads 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, STOP, PARITY.
  - Register offsets: DATA_OFS=0, STAT_OFS=1.
  - STATUS bit positions: busy, full, overflow, parity, count LSB.
- One sub-module, sync_fifo, parameterised on width and depth.
  - Ports: push, pop, din, dout, full, empty, count.
  - Outputs are combinational from registered state; pop returns the head in the same cycle.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Reset, then write 0x55 to DATA → tx low at the next edge. Then per 4-cycle bit: 1,0,1,0,1,0,1,0, stop 1. Total 40 cycles. busy clears after the stop bit.
- Six back-to-back DATA writes 0x01..0x06 → 0x06 is dropped. STATUS read gives full=1, overflow=1, count=4, busy=1. Five frames 0x01..0x05 appear on tx. A second STATUS read gives overflow=0.
- Write to DATA with we=4'b0010 → no push, tx stays 1, STATUS count=0.
- re to an unmapped address and to DATA → rdata=0 on the following cycle. re to STATUS while idle → rdata=0.
- Assert reset 6 cycles into a frame → tx=1 after the reset edge, count=0, no further frame transmitted.
- With UART_TX_PARITY_EN, write 0x07 → parity bit=1 between bit 7 and stop. Frame is 44 cycles. STATUS bit3=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS word layout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;

    localparam logic [29:0] DATA_OFS = 30'd0;
    localparam logic [29:0] STAT_OFS = 30'd1;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_PARITY    = 3;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       overflow,
        input logic       parity_en,
        input logic [4:0] count
    );
        logic [31:0] s;
        s                          = '0;
        s[STAT_BUSY]               = busy;
        s[STAT_FULL]               = full;
        s[STAT_OVERFLOW]           = overflow;
        s[STAT_PARITY]             = parity_en;
        s[STAT_COUNT_LSB +: 5]     = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Small synchronous FIFO; outputs come straight from registered state, so a
// pop sees the head entry in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS registers, byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR  = 30'h0400_0000,
    parameter int          CLK_DIV    = 104,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic        PARITY_FLAG = 1'b1;
`else
    localparam logic        PARITY_FLAG = 1'b0;
`endif

    logic          sel_data, sel_stat, stat_rd;
    logic          push_req, push_ok, pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic [31:0]   status;
    logic          unused_bits;

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   baud_q, baud_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign sel_data    = (addr == BASE_ADDR + DATA_OFS);
    assign sel_stat    = (addr == BASE_ADDR + STAT_OFS);
    assign stat_rd     = re & sel_stat;
    assign push_req    = sel_data & we[0];
    assign push_ok     = push_req & (~fifo_full | pop);
    assign busy        = (state_q != IDLE) | ~fifo_empty;
    assign status      = pack_status(busy, fifo_full, ovf_q, PARITY_FLAG, 5'(fifo_count));
    assign rdata       = rdata_q;
    assign tx          = tx_q;
    // Only the low byte lane carries data; the upper lanes are accepted and ignored.
    assign unused_bits = ^{wdata[31:8], we[3:1]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ovf_d   = ovf_q;
        rdata_d = '0;
        if (stat_rd) begin
            rdata_d = status;
            ovf_d   = 1'b0;
        end
        // A dropped byte in the same cycle as a STATUS read keeps the flag set.
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q == IDLE) begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
                pop       = 1'b1;
                shift_d   = fifo_dout;
                bit_idx_d = 3'd0;
                baud_d    = BAUD_RELOAD;
                tx_d      = 1'b0;
                state_d   = START;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^fifo_dout;
`endif
            end
        end else if (baud_q != 16'd0) begin
            baud_d = baud_q - 16'd1;
        end else begin
            baud_d = BAUD_RELOAD;
            case (state_q)
                START: begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
                DATA: begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
                default: begin
                    tx_d    = 1'b1;
                    baud_d  = 16'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
